// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: ROM port, shared-bus arbitration, branch redirect and decode handshake.
interface instr_fetch_unit_if;
    logic [7:0] rom_addr;
    logic       rom_re_bar;
    logic [7:0] rom_data;
    logic       mem_busy;
    logic       br_taken;
    logic [7:0] br_target;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] q_count;

    modport master (
        output rom_addr, rom_re_bar, instr, instr_pc, instr_valid, q_count,
        input  rom_data, mem_busy, br_taken, br_target, instr_ready
    );

    modport slave (
        input  rom_addr, rom_re_bar, instr, instr_pc, instr_valid, q_count,
        output rom_data, mem_busy, br_taken, br_target, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: fetch PC, ROM read issue, prefetch queue and branch redirect
// for the infinity_mp 8-bit core.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_bar,
    instr_fetch_unit_if.master    bus
);
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  DEPTH_CNT = 4'(DEPTH);

    localparam logic [1:0] S_BOOT     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [7:0]    fetch_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [3:0]    count;
    logic [7:0]    data_mem [DEPTH];
    logic [7:0]    pc_mem   [DEPTH];

    logic          not_empty;
    logic          valid;
    logic          deq;
    logic          fetch;

    // Handshake and fetch qualification; a taken branch kills both in the same cycle.
    assign not_empty = (count != 4'd0);
    assign valid     = not_empty & ~bus.br_taken;
    assign deq       = valid & bus.instr_ready;
    assign fetch     = (state == S_RUN) & ~bus.mem_busy & ~bus.br_taken
                       & ((count < DEPTH_CNT) | deq);

    assign bus.rom_addr    = fetch_pc;
    assign bus.rom_re_bar  = ~fetch;
    assign bus.instr_valid = valid;
    assign bus.instr       = not_empty ? data_mem[rd_ptr] : 8'h00;
    assign bus.instr_pc    = not_empty ? pc_mem[rd_ptr]   : 8'h00;
    assign bus.q_count     = count;

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) state <= S_BOOT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:     state_nxt = S_RUN;
            S_RUN:      state_nxt = S_RUN;
            S_REDIRECT: state_nxt = S_RUN;
            default:    state_nxt = S_BOOT;
        endcase
        if (bus.br_taken) state_nxt = S_REDIRECT;
    end

    // Fetch PC: redirect wins over sequential increment; wraps mod 256.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            fetch_pc <= RESET_PC;
        end else if (bus.br_taken) begin
            fetch_pc <= bus.br_target;
        end else if (fetch) begin
            fetch_pc <= fetch_pc + 8'd1;
        end
    end

    // Queue pointers and occupancy; flush discards any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 4'd0;
        end else if (bus.br_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (fetch) wr_ptr <= wr_ptr + AW'(1);
            if (deq)   rd_ptr <= rd_ptr + AW'(1);
            case ({fetch, deq})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: outputs are muxed to zero while the queue is empty.
    always_ff @(posedge clk) begin
        if (fetch) begin
            data_mem[wr_ptr] <= bus.rom_data;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + short random bench for instr_fetch_unit with a queue-based expected-instruction scoreboard.
module tb_instr_fetch_unit;
    localparam int unsigned DEPTH = 2;
    localparam logic [1:0] M_BOOT  = 2'd0;
    localparam logic [1:0] M_RUN   = 2'd1;
    localparam logic [1:0] M_REDIR = 2'd2;

    logic clk = 1'b0;
    logic rst_bar;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
        .clk     (clk),
        .rst_bar (rst_bar),
        .bus     (bus)
    );

    logic [7:0] rom [256];
    assign bus.rom_data = rom[bus.rom_addr];

    int          total = 0;
    int          bad   = 0;
    logic [15:0] sb [$];
    logic [1:0]  m_state;
    logic [7:0]  m_pc;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_re_bar"}, 16'(bus.rom_re_bar),  16'h1);
        chk({tag, "_valid"},  16'(bus.instr_valid), 16'h0);
        chk({tag, "_instr"},  16'(bus.instr),       16'h0);
        chk({tag, "_ipc"},    16'(bus.instr_pc),    16'h0);
        chk({tag, "_qcnt"},   16'(bus.q_count),     16'h0);
        chk({tag, "_addr"},   16'(bus.rom_addr),    16'h0);
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model across the edge.
    task automatic cycle();
        logic        ev, df, ef, br;
        logic [7:0]  tgt;
        logic [15:0] head;
        #3;
        br   = bus.br_taken;
        tgt  = bus.br_target;
        ev   = (sb.size() != 0) && !br;
        df   = ev && bus.instr_ready;
        ef   = (m_state == M_RUN) && !bus.mem_busy && !br && ((sb.size() < DEPTH) || df);
        head = (sb.size() != 0) ? sb[0] : 16'h0000;
        chk("re_bar", 16'(bus.rom_re_bar),  16'(!ef));
        chk("addr",   16'(bus.rom_addr),    16'(m_pc));
        chk("valid",  16'(bus.instr_valid), 16'(ev));
        chk("qcnt",   16'(bus.q_count),     16'(sb.size()));
        chk("instr",  16'(bus.instr),       16'(head[15:8]));
        chk("ipc",    16'(bus.instr_pc),    16'(head[7:0]));
        @(posedge clk);
        #1;
        if (br) begin
            sb.delete();
            m_pc    = tgt;
            m_state = M_REDIR;
        end else begin
            if (df) void'(sb.pop_front());
            if (ef) begin
                sb.push_back({rom[m_pc], m_pc});
                m_pc = m_pc + 8'd1;
            end
            m_state = M_RUN;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            rom[i]       = 8'(i * 37 + 11);
            rom[i + 128] = rom[i];
        end
        rom[0] = 8'hC1; rom[1] = 8'h02; rom[2] = 8'h43; rom[3] = 8'h84;
        rom[128] = 8'hC1; rom[129] = 8'h02; rom[130] = 8'h43; rom[131] = 8'h84;

        rst_bar         = 1'b0;
        bus.mem_busy    = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = 8'h00;
        bus.instr_ready = 1'b1;
        #2;
        chk_reset_values("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_bar = 1'b1;
        m_state = M_BOOT;
        m_pc    = 8'h00;
        sb.delete();

        // Boot bubble then streaming C1,02,43,84.
        run(7);

        // Decode stalls: queue saturates, pc freezes; release drains in order.
        bus.instr_ready = 1'b0;
        run(5);
        bus.instr_ready = 1'b1;
        run(6);

        // Branch with a full queue.
        bus.instr_ready = 1'b0;
        run(3);
        bus.instr_ready = 1'b1;
        bus.br_taken    = 1'b1;
        bus.br_target   = 8'h10;
        cycle();
        bus.br_taken    = 1'b0;
        run(5);

        // Shared bus busy for two cycles mid-stream.
        bus.mem_busy = 1'b1;
        run(2);
        bus.mem_busy = 1'b0;
        run(4);

        // PC wrap from FF to 00.
        bus.br_taken  = 1'b1;
        bus.br_target = 8'hFF;
        cycle();
        bus.br_taken  = 1'b0;
        run(5);

        // Random mix of stalls, busy cycles and branches.
        for (int i = 0; i < 60; i++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.mem_busy    = ($urandom_range(0, 4) == 0);
            bus.br_taken    = ($urandom_range(0, 9) == 0);
            bus.br_target   = 8'($urandom_range(0, 255));
            cycle();
        end
        bus.mem_busy = 1'b0;
        bus.br_taken = 1'b0;

        // Fill the queue, then reset asynchronously mid-cycle.
        bus.instr_ready = 1'b0;
        run(4);
        chk("full_before_rst", 16'(bus.q_count), 16'(DEPTH));
        #3;
        rst_bar = 1'b0;
        #1;
        chk_reset_values("midrst");
        @(posedge clk);
        #1;
        chk_reset_values("held_rst");
        rst_bar         = 1'b1;
        bus.instr_ready = 1'b1;
        m_state = M_BOOT;
        m_pc    = 8'h00;
        sb.delete();
        run(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
